// File: rtl/step_counter_pkg.sv
// Shared types for the step counter: boundary modes and the run/halt FSM encoding.
package step_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } cnt_mode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } cnt_state_t;

  // Modes that pin at the bound instead of wrapping around it.
  function automatic logic mode_clamps(input cnt_mode_t mode);
    return (mode == MODE_SAT) || (mode == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-count and boundary-event calculation for one count step.
module step_counter_next
  import step_counter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  COUNT,
  input  logic [STEP_W-1:0] STEP,
  input  logic [WIDTH-1:0]  LIMIT,
  input  logic              UP,
  input  cnt_mode_t         MODE,
  output logic [WIDTH-1:0]  NEXT,
  output logic              EVENT
);

  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           event_up;
  logic           event_dn;
  logic           clamp;

  // One extra bit so the carry/borrow is visible; the borrow is exactly COUNT < STEP.
  assign step_ext = (WIDTH+1)'(STEP);
  assign sum      = {1'b0, COUNT} + step_ext;
  assign diff     = {1'b0, COUNT} - step_ext;
  assign event_up = (sum > {1'b0, LIMIT});
  assign event_dn = diff[WIDTH];
  assign clamp    = mode_clamps(MODE);

  always_comb begin
    NEXT  = COUNT;
    EVENT = 1'b0;
    if (UP) begin
      EVENT = event_up;
      if (!event_up)  NEXT = sum[WIDTH-1:0];
      else if (clamp) NEXT = LIMIT;
      else            NEXT = '0;
    end else begin
      EVENT = event_dn;
      if (!event_dn)  NEXT = diff[WIDTH-1:0];
      else if (clamp) NEXT = '0;
      else            NEXT = LIMIT;
    end
  end

endmodule

// File: rtl/step_counter.sv
// Programmable up/down counter with limit, wrap/saturate/one-shot boundary modes,
// terminal-count pulse, sticky overflow flag and a run/halt FSM (DONE = halted).
module step_counter
  import step_counter_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  DATA,
  input  logic              UP,
  input  logic [STEP_W-1:0] STEP,
  input  logic [WIDTH-1:0]  LIMIT,
  input  logic [1:0]        MODE,
  input  logic              CLEAR,
  output logic [WIDTH-1:0]  COUNT,
  output logic              TC,
  output logic              OVF,
  output logic              DONE
);

  cnt_mode_t        mode;
  cnt_state_t       state_q;
  cnt_state_t       state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH-1:0] step_next;
  logic             step_event;
  logic             do_load;
  logic             do_count;
  logic             cnt_event;

  assign mode = cnt_mode_t'(MODE);

  step_counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .COUNT (count_q),
    .STEP  (STEP),
    .LIMIT (LIMIT),
    .UP    (UP),
    .MODE  (mode),
    .NEXT  (step_next),
    .EVENT (step_event)
  );

  // ENABLE qualifies both LOAD and counting; a halted counter ignores count steps.
  assign do_load   = ENABLE && LOAD;
  assign do_count  = ENABLE && !LOAD && (state_q == ST_RUN);
  assign cnt_event = do_count && step_event;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;

    if (do_load) begin
      count_d = DATA;
    end else if (do_count) begin
      count_d = step_next;
      tc_d    = step_event;
    end

    case (state_q)
      ST_RUN: begin
        if (cnt_event && (mode == MODE_ONESHOT)) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (CLEAR || do_load) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // An event on the same edge as CLEAR keeps the flag set.
    if (cnt_event)  ovf_d = 1'b1;
    else if (CLEAR) ovf_d = 1'b0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_RUN;
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign COUNT = count_q;
  assign TC    = tc_q;
  assign OVF   = ovf_q;
  assign DONE  = (state_q == ST_HALT);

endmodule
